// File: rtl/contador_sincrono_crescente.sv
// rtl/contador_sincrono_crescente.sv - modulo-N synchronous up counter with enable, load and terminal count
// Optional sticky overflow flag compiled in with CONTADOR_CRESCENTE_OVF_EN.
module contador_sincrono_crescente #(
    parameter int WIDTH  = 6,
    parameter int MODULO = 64
) (
    input  logic             CK,
    input  logic             CLR,
    input  logic             EN,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC
`ifdef CONTADOR_CRESCENTE_OVF_EN
    ,
    output logic             OVF
`endif
);

    // MODULO may equal 2**WIDTH, so the range check needs one extra bit.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);
    localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULO - 1);

    logic             at_max;
    logic             load_ok;
    logic [WIDTH-1:0] q_next;

    assign at_max  = (Q == Q_MAX);
    assign load_ok = ({1'b0, D} < MOD_EXT);

    always_comb begin
        q_next = Q;
        if (LD) begin
            q_next = load_ok ? D : '0;
        end else if (EN) begin
            q_next = at_max ? '0 : Q + WIDTH'(1);
        end
    end

    always_ff @(posedge CK or negedge CLR) begin
        if (!CLR) begin
            Q <= '0;
        end else begin
            Q <= q_next;
        end
    end

    // Carry into the next stage's EN; load is deliberately ignored here.
    assign TC = EN & at_max;

`ifdef CONTADOR_CRESCENTE_OVF_EN
    always_ff @(posedge CK or negedge CLR) begin
        if (!CLR) begin
            OVF <= 1'b0;
        end else if (LD) begin
            OVF <= 1'b0;
        end else if (EN && at_max) begin
            OVF <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_contador_sincrono_crescente.sv
// tb/tb_contador_sincrono_crescente.sv - directed self-checking bench for contador_sincrono_crescente
module tb_contador_sincrono_crescente;

    logic       ck;
    logic       clr0, en0, ld0;
    logic [5:0] d0, q0;
    logic       tc0;
    logic       clr5, en5, ld5;
    logic [6:0] d5, q5;
    logic       tc5;
    logic       clrc, enc;
    logic [3:0] qc0, qc1;
    logic       tcc0, tcc1;
`ifdef CONTADOR_CRESCENTE_OVF_EN
    logic       ovf0, ovf5, ovfc0, ovfc1;
`endif

    int total = 0;
    int bad   = 0;

    initial ck = 1'b0;
    always #10 ck = ~ck;

    contador_sincrono_crescente #(.WIDTH(6), .MODULO(64)) u_dut0 (
        .CK(ck), .CLR(clr0), .EN(en0), .LD(ld0), .D(d0), .Q(q0), .TC(tc0)
`ifdef CONTADOR_CRESCENTE_OVF_EN
        , .OVF(ovf0)
`endif
    );

    contador_sincrono_crescente #(.WIDTH(7), .MODULO(50)) u_dut50 (
        .CK(ck), .CLR(clr5), .EN(en5), .LD(ld5), .D(d5), .Q(q5), .TC(tc5)
`ifdef CONTADOR_CRESCENTE_OVF_EN
        , .OVF(ovf5)
`endif
    );

    contador_sincrono_crescente #(.WIDTH(4), .MODULO(10)) u_stage0 (
        .CK(ck), .CLR(clrc), .EN(enc), .LD(1'b0), .D(4'd0), .Q(qc0), .TC(tcc0)
`ifdef CONTADOR_CRESCENTE_OVF_EN
        , .OVF(ovfc0)
`endif
    );

    contador_sincrono_crescente #(.WIDTH(4), .MODULO(10)) u_stage1 (
        .CK(ck), .CLR(clrc), .EN(tcc0), .LD(1'b0), .D(4'd0), .Q(qc1), .TC(tcc1)
`ifdef CONTADOR_CRESCENTE_OVF_EN
        , .OVF(ovfc1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    initial begin
        clr0 = 1'b0; en0 = 1'b1; ld0 = 1'b0; d0 = '0;
        clr5 = 1'b0; en5 = 1'b0; ld5 = 1'b0; d5 = '0;
        clrc = 1'b0; enc = 1'b0;

        #12;
        chk("reset_q", 32'(q0), 0);
        chk("reset_tc", 32'(tc0), 0);
`ifdef CONTADOR_CRESCENTE_OVF_EN
        chk("reset_ovf", 32'(ovf0), 0);
`endif
        #3;
        clr0 = 1'b1; clr5 = 1'b1; clrc = 1'b1;

        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("count_after_reset", 32'(q0), 32'(i));
            chk("tc_low_early", 32'(tc0), 0);
        end

        for (int i = 4; i <= 63; i++) begin
            tick();
            chk("count_up", 32'(q0), 32'(i));
        end
        chk("tc_at_63", 32'(tc0), 1);
        tick();
        chk("wrap_q", 32'(q0), 0);
        chk("wrap_tc", 32'(tc0), 0);
`ifdef CONTADOR_CRESCENTE_OVF_EN
        chk("ovf_set", 32'(ovf0), 1);
`endif
        tick();
        chk("after_wrap_q", 32'(q0), 1);
`ifdef CONTADOR_CRESCENTE_OVF_EN
        chk("ovf_sticky", 32'(ovf0), 1);
`endif

        ld0 = 1'b1; d0 = 6'd10; en0 = 1'b0;
        tick();
        chk("load_10", 32'(q0), 10);
`ifdef CONTADOR_CRESCENTE_OVF_EN
        chk("ovf_cleared_by_load", 32'(ovf0), 0);
`endif
        d0 = 6'd40; en0 = 1'b1;
        tick();
        chk("load_beats_en", 32'(q0), 40);

        d0 = 6'd63; en0 = 1'b0;
        tick();
        ld0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_q", 32'(q0), 63);
            chk("hold_tc", 32'(tc0), 0);
        end
        en0 = 1'b1;
        #1;
        chk("tc_comb_on_en", 32'(tc0), 1);
        ld0 = 1'b1;
        #1;
        chk("tc_ignores_ld", 32'(tc0), 1);
        ld0 = 1'b0; en0 = 1'b0;

        ld0 = 1'b1; d0 = 6'd37;
        tick();
        ld0 = 1'b0; en0 = 1'b1;
        chk("load_37", 32'(q0), 37);
        #5;
        clr0 = 1'b0;
        #1;
        chk("mid_reset_q", 32'(q0), 0);
        chk("mid_reset_tc", 32'(tc0), 0);
`ifdef CONTADOR_CRESCENTE_OVF_EN
        chk("mid_reset_ovf", 32'(ovf0), 0);
`endif
        #3;
        clr0 = 1'b1;
        tick();
        chk("resume_after_reset", 32'(q0), 1);

        ld5 = 1'b1; d5 = 7'd40;
        tick();
        chk("m50_load_40", 32'(q5), 40);
        d5 = 7'd70;
        tick();
        chk("m50_clamp_70", 32'(q5), 0);
        d5 = 7'd49;
        tick();
        chk("m50_load_49", 32'(q5), 49);
        ld5 = 1'b0; en5 = 1'b1;
        #1;
        chk("m50_tc_at_49", 32'(tc5), 1);
        tick();
        chk("m50_wrap", 32'(q5), 0);
        en5 = 1'b0; ld5 = 1'b1; d5 = 7'd50;
        tick();
        chk("m50_clamp_50", 32'(q5), 0);
        ld5 = 1'b0;

        enc = 1'b1;
        for (int i = 1; i <= 9; i++) tick();
        chk("casc_09_ones", 32'(qc0), 9);
        chk("casc_09_tens", 32'(qc1), 0);
        chk("casc_09_tc0", 32'(tcc0), 1);
        chk("casc_09_tc1", 32'(tcc1), 0);
        tick();
        chk("casc_10_ones", 32'(qc0), 0);
        chk("casc_10_tens", 32'(qc1), 1);
        for (int i = 11; i <= 90; i++) tick();
        chk("casc_90_tens", 32'(qc1), 9);
        chk("casc_90_tc1", 32'(tcc1), 0);
        for (int i = 91; i <= 99; i++) tick();
        chk("casc_99_ones", 32'(qc0), 9);
        chk("casc_99_tens", 32'(qc1), 9);
        chk("casc_99_tc1", 32'(tcc1), 1);
        tick();
        chk("casc_00_ones", 32'(qc0), 0);
        chk("casc_00_tens", 32'(qc1), 0);
        chk("casc_00_tc1", 32'(tcc1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/contador_sincrono_crescente.md
# contador_sincrono_crescente

Synchronous modulo-N up counter. It is the ascending counterpart of the existing 6-bit down counter in the counter exercise set, with the same `CK` clock and `CLR` clear naming. Adds count enable, parallel load, and a terminal-count output so stages can be cascaded into wider counters. An optional sticky overflow flag can be compiled in.

## Interface
- `WIDTH`, default 6: counter width in bits.
- `MODULO`, default 64: count modulus. Must satisfy 2 ≤ `MODULO` ≤ 2**`WIDTH`.
- `CK` input, 1 bit: clock. All state changes on its rising edge.
- `CLR` input, 1 bit: reset.
  - Asynchronous and active-low.
  - `CLR`=0 forces every output to its reset value immediately, independent of `CK`.
- `EN` input, 1 bit: count enable, active-high.
- `LD` input, 1 bit: synchronous parallel load, active-high.
- `D` input, `WIDTH` bits: load value.
- `Q` output, `WIDTH` bits: current count.
- `TC` output, 1 bit: terminal count / carry to the next stage.
- `OVF` output, 1 bit: sticky overflow. Present only with `CONTADOR_CRESCENTE_OVF_EN`.

## Operation
- Reset values: `Q`=0, `TC`=0, `OVF`=0.
- Priority on each rising `CK` edge, highest first:
  - `CLR`=0 → hold reset; nothing else applies.
  - `LD`=1 → load from `D`:
    - `Q` ← `D` when `D` < `MODULO`.
    - `Q` ← 0 when `D` ≥ `MODULO`; an out-of-range load is clamped to 0.
  - `EN`=1 → increment:
    - `Q` ← `Q`+1 when `Q` < `MODULO`−1.
    - `Q` ← 0 when `Q` = `MODULO`−1 (wrap).
  - Otherwise → `Q` holds.
- `TC` = `EN` AND (`Q` = `MODULO`−1).
  - Combinational from registered `Q` and `EN`.
  - Independent of `LD`.
  - Drives the next stage's `EN` for ripple-free synchronous cascading.
- Arithmetic is modulo `MODULO`.
  - The increment is computed at `WIDTH` bits.
  - `MODULO` = 2**`WIDTH` wraps naturally through all ones → 0.
- Simultaneous `LD`=1 and `EN`=1: the load wins and no increment happens that cycle.
- Reset mid-count: `Q` returns to 0 asynchronously.
  - Counting resumes from 0 on the first rising edge after `CLR` returns to 1 with `EN`=1.

## Timing
- Latency: one `CK` edge from `EN`/`LD` sampled to new `Q`. No pipeline.
- `TC` is valid in the same cycle `Q` = `MODULO`−1 with `EN`=1.
  - The wrap to 0 occurs on the next rising edge.
- `CLR` assertion acts within the same delta cycle. Release is synchronous in effect: the first update happens on the next rising edge.
- Cascade of k stages: full count period = product of the moduli, with all `Q` bits changing on the same edge.

## Configuration
- Macro: `CONTADOR_CRESCENTE_OVF_EN`.
- Defined:
  - `OVF` port exists, registered.
  - Set to 1 on any edge where the counter wraps `MODULO`−1 → 0 via `EN`.
  - Cleared only by `CLR`=0 or by a load (`LD`=1).
  - Stays 1 across further counting.
- Undefined: no `OVF` port and no associated register. All other behaviour is identical.

## Test plan
All scenarios use a 20 ns clock period and the default parameters unless noted.

- Reset: `CLR`=0 for 15 ns, then 1, with `EN`=1 → `Q`=0 during reset; `Q`=1,2,3… on the following edges; `TC`=0.
- Full wrap: `EN`=1 for 64 edges → `Q` reaches 63 with `TC`=1, then 0 on the next edge. With the macro defined, `OVF`=1 afterward and stays 1.
- Load/enable priority: `Q`=10, `LD`=1, `D`=40, `EN`=1 → `Q`=40, not 11. Then `LD`=1, `D`=70 with `MODULO`=50 → `Q`=0.
- Hold: `EN`=0, `LD`=0 at `Q`=63 for 5 edges → `Q` stays 63 and `TC`=0.
- Mid-count reset: `CLR`=0 at `Q`=37 between edges → `Q`=0 immediately and `OVF`=0. After release, `Q`=1 on the next edge.
- Cascade, `MODULO`=10: stage0 `TC` drives stage1 `EN` → sequence 09 → 10, 99 → 00. Stage1 `TC`=1 only at 99.
